ps2_key_decoder: RTL and testbench

Receives the PS/2 keyboard serial stream and turns it into held-key levels for the game logic. It deserialises 11-bit PS/2 frames, checks them, and tracks the E0 (extended) and F0 (break) prefixes. It drives `leftPressed`, `rightPressed`, `upPressed` and `downPressed`, plus `jumpPressed` and `startPressed`, which feed the monkey movement block and the game state logic. It is the producer side of the pressed-key interface that the movement logic samples every clock.

---
 rtl/ps2_pkg.sv | 39 +++
 rtl/ps2_frame_rx.sv | 133 +++++++++++++
 rtl/ps2_key_decoder.sv | 127 ++++++++++++
 tb/tb_ps2_key_decoder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg
//   Shared definitions for the PS/2 keyboard receive path:
//   - scan-code constants for the prefixes and the keys the game uses
//   - state enums for the frame receiver and the prefix decoder
//   - odd-parity helper used by the frame receiver
package ps2_pkg;

  // Prefix bytes
  localparam logic [7:0] SC_EXT   = 8'hE0;  // extended-key prefix
  localparam logic [7:0] SC_BRK   = 8'hF0;  // break (release) prefix

  // Game keys (set 2 make codes; arrows share codes with keypad 8/2/4/6)
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ENTER = 8'h5A;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rxState_t;

  typedef enum logic [1:0] {
    ST_BASE,
    ST_EXT,
    ST_BRK,
    ST_EXTBRK
  } decState_t;

  // True when the 8 data bits plus the parity bit hold an odd number of ones.
  function automatic logic oddParityOk(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx
//   Deserialises 11-bit PS/2 frames (start, 8 data LSB first, odd parity,
//   stop) from the raw keyboard pins.
//
// Ports
//   clk      in   system clock
//   resetN   in   asynchronous reset, active-high
//   ps2Clk   in   raw PS/2 clock pin (asynchronous)
//   ps2Data  in   raw PS/2 data pin (asynchronous)
//   rxByte   out  received data byte, qualified by rxValid
//   rxValid  out  one-cycle pulse: frame passed parity and stop checks
//   rxError  out  one-cycle pulse: parity/stop failure or mid-frame timeout
//
// rxValid/rxError are combinational in the cycle the synced stop-bit falling
// edge is seen, so the consumer registers them one clock later.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  output logic [7:0] rxByte,
  output logic       rxValid,
  output logic       rxError
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic             ps2ClkMeta, ps2ClkSync, ps2ClkPrev;
  logic             ps2DataMeta, ps2DataSync;
  logic             fallEdge;
  logic             timeoutHit;
  logic             frameOk;

  rxState_t         rxState, rxNext;
  logic [7:0]       shiftReg;
  logic [2:0]       bitCnt;
  logic             parityBit;
  logic [CNT_W-1:0] timeoutCnt;

  // Two-flop synchronisers plus one history flop for edge detection.
  // The pins idle high, so the flops reset high to avoid a false edge.
  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      ps2ClkMeta  <= 1'b1;
      ps2ClkSync  <= 1'b1;
      ps2ClkPrev  <= 1'b1;
      ps2DataMeta <= 1'b1;
      ps2DataSync <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make each stage take the previous
      // stage's old value, which is what builds a real shift chain.
      ps2ClkMeta  <= ps2Clk;
      ps2ClkSync  <= ps2ClkMeta;
      ps2ClkPrev  <= ps2ClkSync;
      ps2DataMeta <= ps2Data;
      ps2DataSync <= ps2DataMeta;
    end
  end

  assign fallEdge = ps2ClkPrev & ~ps2ClkSync;

  // A falling edge in the same cycle clears the counter, so timeout and a
  // frame completion can never coincide.
  assign timeoutHit = (rxState != RX_IDLE) && !fallEdge && (timeoutCnt == TIMEOUT_LIMIT);

  // State register
  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) rxState <= RX_IDLE;
    else        rxState <= rxNext;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first so every path assigns rxNext and no latch is inferred.
    rxNext = rxState;
    if (timeoutHit) begin
      rxNext = RX_IDLE;
    end else if (fallEdge) begin
      case (rxState)
        RX_IDLE:   if (!ps2DataSync) rxNext = RX_DATA;  // data 1 is a glitch
        RX_DATA:   if (bitCnt == 3'd7) rxNext = RX_PARITY;
        RX_PARITY: rxNext = RX_STOP;
        RX_STOP:   rxNext = RX_IDLE;
        default:   rxNext = RX_IDLE;
      endcase
    end
  end

  // Output logic
  assign frameOk = oddParityOk(shiftReg, parityBit) && ps2DataSync;

  always_comb begin
    rxValid = 1'b0;
    rxError = timeoutHit;
    if (fallEdge && rxState == RX_STOP) begin
      rxValid = frameOk;
      rxError = !frameOk;
    end
  end

  assign rxByte = shiftReg;

  // Datapath: shift register, bit counter, parity capture and timeout.
  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      shiftReg   <= '0;
      bitCnt     <= '0;
      parityBit  <= 1'b0;
      timeoutCnt <= '0;
    end else begin
      if (fallEdge || rxState == RX_IDLE || timeoutHit) timeoutCnt <= '0;
      else                                              timeoutCnt <= timeoutCnt + 1'b1;

      if (fallEdge) begin
        case (rxState)
          RX_IDLE:   bitCnt <= '0;
          RX_DATA: begin
            shiftReg <= {ps2DataSync, shiftReg[7:1]};  // LSB arrives first
            bitCnt   <= bitCnt + 3'd1;
          end
          RX_PARITY: parityBit <= ps2DataSync;
          default:   ;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
//   Turns the PS/2 keyboard stream into held-key levels for the game.
//   Frames are received by ps2_frame_rx; this level tracks the E0/F0 prefix
//   state and keeps one level register per game key.
//
// Ports
//   clk             in   system clock
//   resetN          in   asynchronous reset, active-high
//   ps2Clk/ps2Data  in   raw PS/2 pins (asynchronous)
//   leftPressed, rightPressed, upPressed, downPressed  out  direction levels
//   jumpPressed     out  Space held
//   startPressed    out  Enter held
//   keyCode         out  last accepted non-prefix scan code
//   keyBreak        out  that code was a release
//   keyExtended     out  that code was E0-prefixed
//   keyValid        out  one-cycle pulse when keyCode/keyBreak/keyExtended update
//   frameError      out  one-cycle pulse on parity, stop-bit or timeout failure
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  output logic       leftPressed,
  output logic       rightPressed,
  output logic       upPressed,
  output logic       downPressed,
  output logic       jumpPressed,
  output logic       startPressed,
  output logic [7:0] keyCode,
  output logic       keyBreak,
  output logic       keyExtended,
  output logic       keyValid,
  output logic       frameError
);

  logic [7:0] rxByte;
  logic       rxValid;
  logic       rxError;

  decState_t  decState, decNext;
  logic       keyDone;
  logic       doneBreak;
  logic       doneExt;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame_rx (
    .clk     (clk),
    .resetN  (resetN),
    .ps2Clk  (ps2Clk),
    .ps2Data (ps2Data),
    .rxByte  (rxByte),
    .rxValid (rxValid),
    .rxError (rxError)
  );

  // Prefix state register
  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) decState <= ST_BASE;
    else        decState <= decNext;
  end

  // Prefix next-state: one transition per accepted byte; any failed frame
  // drops a half-received prefix sequence.
  always_comb begin
    decNext = decState;
    if (rxError) begin
      decNext = ST_BASE;
    end else if (rxValid) begin
      if (rxByte == SC_EXT) begin
        if (decState == ST_BASE) decNext = ST_EXT;
      end else if (rxByte == SC_BRK) begin
        if (decState == ST_BASE)     decNext = ST_BRK;
        else if (decState == ST_EXT) decNext = ST_EXTBRK;
      end else begin
        decNext = ST_BASE;
      end
    end
  end

  // Prefix outputs: a completed key and the attributes it carries.
  always_comb begin
    keyDone   = rxValid && (rxByte != SC_EXT) && (rxByte != SC_BRK);
    doneBreak = (decState == ST_BRK) || (decState == ST_EXTBRK);
    doneExt   = (decState == ST_EXT) || (decState == ST_EXTBRK);
  end

  // Registered key report and held-key levels. The prefix is ignored for the
  // mapping, so arrow keys and keypad 8/2/4/6 drive the same level.
  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      keyCode      <= '0;
      keyBreak     <= 1'b0;
      keyExtended  <= 1'b0;
      keyValid     <= 1'b0;
      frameError   <= 1'b0;
      leftPressed  <= 1'b0;
      rightPressed <= 1'b0;
      upPressed    <= 1'b0;
      downPressed  <= 1'b0;
      jumpPressed  <= 1'b0;
      startPressed <= 1'b0;
    end else begin
      keyValid   <= keyDone;
      frameError <= rxError;
      if (keyDone) begin
        keyCode     <= rxByte;
        keyBreak    <= doneBreak;
        keyExtended <= doneExt;
        case (rxByte)
          SC_UP:    upPressed    <= !doneBreak;
          SC_DOWN:  downPressed  <= !doneBreak;
          SC_LEFT:  leftPressed  <= !doneBreak;
          SC_RIGHT: rightPressed <= !doneBreak;
          SC_SPACE: jumpPressed  <= !doneBreak;
          SC_ENTER: startPressed <= !doneBreak;
          default:  ;  // unmapped codes only update the key report
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder
//   Directed bench for ps2_key_decoder: bit-bangs PS/2 frames on the pins
//   and checks levels, key reports and error pulses against hand-computed
//   values. A monitor counts pulses and flags pulse-protocol violations.
module tb_ps2_key_decoder;

  localparam int TIMEOUT = 200;  // shortened so the gap test stays fast
  localparam int HALF    = 8;    // PS/2 half-period in clk cycles

  logic       clk = 1'b0;
  logic       resetN;
  logic       ps2Clk;
  logic       ps2Data;
  logic       leftPressed, rightPressed, upPressed, downPressed;
  logic       jumpPressed, startPressed;
  logic [7:0] keyCode;
  logic       keyBreak, keyExtended, keyValid, frameError;

  logic [5:0] levels;  // {up, down, left, right, jump, start}
  assign levels = {upPressed, downPressed, leftPressed, rightPressed, jumpPressed, startPressed};

  int assertCount   = 0;
  int failCount     = 0;
  int cycleCnt      = 0;
  int kvCount       = 0;
  int feCount       = 0;
  int kvCycle       = 0;
  int stopEdgeCycle = 0;
  int protoViol     = 0;
  logic       prevKv = 1'b0;
  logic       prevFe = 1'b0;
  logic [5:0] prevLevels = '0;

  ps2_key_decoder #(
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk          (clk),
    .resetN       (resetN),
    .ps2Clk       (ps2Clk),
    .ps2Data      (ps2Data),
    .leftPressed  (leftPressed),
    .rightPressed (rightPressed),
    .upPressed    (upPressed),
    .downPressed  (downPressed),
    .jumpPressed  (jumpPressed),
    .startPressed (startPressed),
    .keyCode      (keyCode),
    .keyBreak     (keyBreak),
    .keyExtended  (keyExtended),
    .keyValid     (keyValid),
    .frameError   (frameError)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt++;

  // Pulse monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (keyValid) begin
      kvCount++;
      kvCycle = cycleCnt;
    end
    if (frameError) feCount++;
    if (keyValid && frameError) protoViol++;
    if (keyValid && prevKv) protoViol++;
    if (frameError && prevFe) protoViol++;
    if (levels != prevLevels && !keyValid) protoViol++;
    if ($countones(levels ^ prevLevels) > 1) protoViol++;
    prevKv     = keyValid;
    prevFe     = frameError;
    prevLevels = levels;
  end

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Sends the first nBits of a frame (start, data LSB first, parity, stop).
  task automatic sendBits(input logic [7:0] data, input int nBits, input logic badParity);
    logic [10:0] frame;
    frame = {1'b1, (~^data) ^ badParity, data, 1'b0};
    for (int i = 0; i < nBits; i++) begin
      @(posedge clk); #1 ps2Data = frame[i];
      repeat (HALF) @(posedge clk);
      #1 ps2Clk = 1'b0;
      if (i == 10) stopEdgeCycle = cycleCnt;
      repeat (HALF) @(posedge clk);
      #1 ps2Clk = 1'b1;
    end
  endtask

  task automatic sendFrame(input logic [7:0] data, input logic badParity = 1'b0);
    sendBits(data, 11, badParity);
    ps2Data = 1'b1;
    repeat (20) @(posedge clk);
    #1;
  endtask

  initial begin
    resetN  = 1'b1;
    ps2Clk  = 1'b1;
    ps2Data = 1'b1;
    repeat (5) @(posedge clk);
    #1 resetN = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    check("reset levels", 32'(levels), 32'h0);
    check("reset keyCode", 32'(keyCode), 32'h0);
    check("reset flags", 32'({keyBreak, keyExtended, keyValid, frameError}), 32'h0);

    // Reset mid-frame after 5 bits discards the partial byte.
    sendBits(8'h6B, 5, 1'b0);
    resetN = 1'b1;
    repeat (4) @(posedge clk);
    #1 resetN = 1'b0;
    ps2Data = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("aborted frame pulses", 32'(kvCount + feCount), 32'd0);

    sendFrame(8'h6B);
    check("left make", 32'(leftPressed), 32'd1);
    check("left keyCode", 32'(keyCode), 32'h6B);
    check("left keyValid count", 32'(kvCount), 32'd1);
    check("make latency in 3..4", 32'((kvCycle - stopEdgeCycle) >= 3 && (kvCycle - stopEdgeCycle) <= 4), 32'd1);

    // Extended up make then extended up break.
    sendFrame(8'hE0);
    sendFrame(8'h75);
    check("up make level", 32'(upPressed), 32'd1);
    check("up make ext/brk", 32'({keyExtended, keyBreak}), 32'b10);
    check("up make code", 32'(keyCode), 32'h75);
    sendFrame(8'hE0);
    sendFrame(8'hF0);
    sendFrame(8'h75);
    check("up break level", 32'(upPressed), 32'd0);
    check("up break ext/brk", 32'({keyExtended, keyBreak}), 32'b11);
    check("up keyValid count", 32'(kvCount), 32'd3);

    // Bad parity is rejected, the retry is accepted.
    sendFrame(8'h74, 1'b1);
    check("bad parity error", 32'(feCount), 32'd1);
    check("bad parity right", 32'(rightPressed), 32'd0);
    check("bad parity no key", 32'(kvCount), 32'd3);
    sendFrame(8'h74);
    check("right make", 32'(rightPressed), 32'd1);
    check("left+right held", 32'({leftPressed, rightPressed}), 32'b11);

    sendFrame(8'hF0);
    sendFrame(8'h6B);
    check("left break only", 32'({leftPressed, rightPressed}), 32'b01);
    check("left break flags", 32'({keyExtended, keyBreak}), 32'b01);

    // Timeout after E0 and a partial frame resets the prefix state.
    sendFrame(8'h29);
    check("jump make", 32'(jumpPressed), 32'd1);
    sendFrame(8'hE0);
    sendBits(8'h12, 8, 1'b0);
    ps2Data = 1'b1;
    repeat (TIMEOUT + 100) @(posedge clk);
    #1;
    check("timeout error", 32'(feCount), 32'd2);
    check("timeout no key", 32'(kvCount), 32'd6);
    sendFrame(8'hF0);
    sendFrame(8'h29);
    check("jump break", 32'(jumpPressed), 32'd0);
    check("jump break flags", 32'({keyExtended, keyBreak}), 32'b01);

    sendFrame(8'h72);
    check("down make", 32'(downPressed), 32'd1);
    sendFrame(8'h5A);
    check("start make", 32'(startPressed), 32'd1);
    sendFrame(8'hF0);
    sendFrame(8'h5A);
    check("start break", 32'(startPressed), 32'd0);

    // Unmapped code: key report only.
    sendFrame(8'hAA);
    check("AA keyCode", 32'(keyCode), 32'hAA);
    check("AA keyValid count", 32'(kvCount), 32'd11);
    check("AA levels unchanged", 32'(levels), 32'b010100);
    check("AA flags", 32'({keyExtended, keyBreak}), 32'b00);

    check("error count final", 32'(feCount), 32'd2);
    check("pulse protocol violations", 32'(protoViol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
